mem_req_arbiter: RTL and testbench

//  Shares one MMU-style memory request port between instruction fetch (read-only) and the data path (load/store).

---
 rtl/riscv_arb_pkg.sv | 31 +++
 rtl/arb_watchdog.sv | 54 +++++
 rtl/mem_req_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_mem_req_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_arb_pkg.sv
// ----------------------------------------------------------------------------
// riscv_arb_pkg
//   Shared types and constants for the memory request arbiter:
//     arb_state_t  - arbiter FSM states (IDLE -> ISSUE -> WAIT -> IDLE)
//     arb_owner_t  - which requester owns the in-flight transaction
//     FUNC3_LW     - size code driven to memory for instruction fetches
//     pick_owner() - fixed data priority, with ifetch forced in once starved
// ----------------------------------------------------------------------------
package riscv_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } arb_owner_t;

    localparam logic [2:0] FUNC3_LW = 3'b010;

    // Data wins unless ifetch is also waiting and has been passed over too often.
    function automatic arb_owner_t pick_owner(input logic d_req,
                                              input logic if_req,
                                              input logic starved);
        return (d_req && !(if_req && starved)) ? OWN_D : OWN_IF;
    endfunction

endpackage

// File: rtl/arb_watchdog.sv
// ----------------------------------------------------------------------------
// arb_watchdog
//   Counts cycles spent waiting for a memory response and flags a lost one.
//   Ports:
//     cpu_clk_gated  in   clock
//     i_rstn         in   asynchronous active-low reset
//     start_i        in   transaction is entering WAIT next cycle (clear count)
//     run_i          in   arbiter is in WAIT this cycle (count)
//     resp_i         in   owner's response is present this cycle
//     expire_o       out  last allowed WAIT cycle passed with no response
//     timeout_o      out  sticky: some transaction has been abandoned
// ----------------------------------------------------------------------------
module arb_watchdog #(
    parameter int TIMEOUT_CYC = 256
) (
    input  logic cpu_clk_gated,
    input  logic i_rstn,
    input  logic start_i,
    input  logic run_i,
    input  logic resp_i,
    output logic expire_o,
    output logic timeout_o
);
    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;

    // The count is 0 in the first WAIT cycle, so TIMEOUT_CYC-1 marks the last one.
    // A real response in that same cycle wins over the watchdog.
    assign expire_o  = run_i && !resp_i && (cnt_q == CW'(TIMEOUT_CYC - 1));
    assign timeout_o = timeout_q;

    always_comb begin
        cnt_d     = cnt_q;
        timeout_d = timeout_q || expire_o;
        if (start_i) begin
            cnt_d = '0;
        end else if (run_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge cpu_clk_gated or negedge i_rstn) begin
        if (!i_rstn) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// ----------------------------------------------------------------------------
// mem_req_arbiter
//   Shares one memory request port between instruction fetch (read-only) and
//   the load/store data path. One transaction in flight, data has priority,
//   ifetch is forced in after STARVE_LIMIT consecutive data grants, and a
//   watchdog abandons transactions whose response never arrives.
//   Ports:
//     cpu_clk_gated, i_rstn           clock, asynchronous active-low reset
//     if_req/if_addr                  ifetch request, held until if_rvalid
//     if_gnt/if_rvalid/if_rdata       ifetch capture pulse, data pulse, data
//     d_req/d_we/d_func3/d_addr/d_wdata  data request, held until d_done
//     d_gnt/d_done/d_rdata            data capture pulse, completion, load data
//     m_req/m_we/m_func3/m_addr/m_wdata  request pulse and captured fields
//     m_done/m_rvalid/m_rdata         write-complete, read-valid, read data
//     arb_busy                        FSM not idle
//     arb_timeout                     sticky lost-response flag
// ----------------------------------------------------------------------------
module mem_req_arbiter
    import riscv_arb_pkg::*;
#(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT_CYC  = 256
) (
    input  logic          cpu_clk_gated,
    input  logic          i_rstn,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [2:0]    d_func3,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_done,
    output logic [DW-1:0] d_rdata,
    output logic          m_req,
    output logic          m_we,
    output logic [2:0]    m_func3,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic          m_done,
    input  logic          m_rvalid,
    input  logic [DW-1:0] m_rdata,
    output logic          arb_busy,
    output logic          arb_timeout
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    arb_state_t    state_q, state_d;
    arb_owner_t    owner_q, pick;
    logic [SW-1:0] streak_q, streak_d;
    logic          m_we_q;
    logic [2:0]    m_func3_q;
    logic [AW-1:0] m_addr_q;
    logic [DW-1:0] m_wdata_q;
    logic          if_rvalid_q, d_done_q;
    logic [DW-1:0] if_rdata_q, d_rdata_q;
    logic          owner_rd, resp_hit, arb_go, finish, wd_expire, wd_start;

    always_comb begin
        owner_rd = (owner_q == OWN_IF) || !m_we_q;
        // Only the response type matching the owner's operation counts, in ISSUE or WAIT.
        resp_hit = ((state_q == ARB_ISSUE) || (state_q == ARB_WAIT))
                && (owner_rd ? m_rvalid : m_done);
        // The completion cycle is skipped: the finished requester still shows its old request.
        arb_go   = (state_q == ARB_IDLE) && !(if_rvalid_q || d_done_q) && (if_req || d_req);
        pick     = pick_owner(d_req, if_req, streak_q == SW'(STARVE_LIMIT));
        finish   = resp_hit || wd_expire;
        wd_start = (state_q == ARB_ISSUE) && !resp_hit;
    end

    arb_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .cpu_clk_gated (cpu_clk_gated),
        .i_rstn        (i_rstn),
        .start_i       (wd_start),
        .run_i         (state_q == ARB_WAIT),
        .resp_i        (resp_hit),
        .expire_o      (wd_expire),
        .timeout_o     (arb_timeout)
    );

    // NOTE: every combinational output gets a default first, so no path infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_IDLE:  if (arb_go) state_d = ARB_ISSUE;
            ARB_ISSUE: state_d = resp_hit ? ARB_IDLE : ARB_WAIT;
            ARB_WAIT:  if (finish) state_d = ARB_IDLE;
            default:   state_d = ARB_IDLE;
        endcase
    end

    // Streak of data grants taken while ifetch was waiting; saturates at the limit.
    always_comb begin
        streak_d = streak_q;
        if (!if_req) begin
            streak_d = '0;
        end else if (arb_go && (pick == OWN_IF)) begin
            streak_d = '0;
        end else if (arb_go && (streak_q != SW'(STARVE_LIMIT))) begin
            streak_d = streak_q + SW'(1);
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge cpu_clk_gated or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q  <= ARB_IDLE;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
        end
    end

    // Owner and memory fields are captured at the IDLE->ISSUE edge and held until the next grant.
    always_ff @(posedge cpu_clk_gated or negedge i_rstn) begin
        if (!i_rstn) begin
            owner_q   <= OWN_IF;
            m_we_q    <= 1'b0;
            m_func3_q <= '0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
        end else if (arb_go) begin
            owner_q <= pick;
            if (pick == OWN_D) begin
                m_we_q    <= d_we;
                m_func3_q <= d_func3;
                m_addr_q  <= d_addr;
                m_wdata_q <= d_wdata;
            end else begin
                m_we_q    <= 1'b0;
                m_func3_q <= FUNC3_LW;
                m_addr_q  <= if_addr;
                m_wdata_q <= '0;
            end
        end
    end

    // Completion pulses and read data, routed to the owner; an abandoned transaction returns 0.
    always_ff @(posedge cpu_clk_gated or negedge i_rstn) begin
        if (!i_rstn) begin
            if_rvalid_q <= 1'b0;
            d_done_q    <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            if_rvalid_q <= finish && (owner_q == OWN_IF);
            d_done_q    <= finish && (owner_q == OWN_D);
            if (finish && (owner_q == OWN_IF)) begin
                if_rdata_q <= wd_expire ? '0 : m_rdata;
            end
            if (finish && (owner_q == OWN_D) && (owner_rd || wd_expire)) begin
                d_rdata_q <= wd_expire ? '0 : m_rdata;
            end
        end
    end

    always_comb begin
        m_req    = (state_q == ARB_ISSUE);
        if_gnt   = m_req && (owner_q == OWN_IF);
        d_gnt    = m_req && (owner_q == OWN_D);
        arb_busy = (state_q != ARB_IDLE);
    end

    assign m_we      = m_we_q;
    assign m_func3   = m_func3_q;
    assign m_addr    = m_addr_q;
    assign m_wdata   = m_wdata_q;
    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_done    = d_done_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_req_arbiter
//   Directed scenarios (reset mid-WAIT, single load, store, contention order,
//   early response, timeout) followed by randomized transactions, all checked
//   against a transaction-level model of the arbitration and routing rules.
// ----------------------------------------------------------------------------
module tb_mem_req_arbiter;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int LIMIT = 4;
    localparam int TMO   = 16;

    logic          cpu_clk_gated = 1'b0;
    logic          i_rstn;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt, if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req, d_we;
    logic [2:0]    d_func3;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt, d_done;
    logic [DW-1:0] d_rdata;
    logic          m_req, m_we;
    logic [2:0]    m_func3;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_done, m_rvalid;
    logic [DW-1:0] m_rdata;
    logic          arb_busy, arb_timeout;

    int n_vec    = 0;
    int n_err    = 0;
    int streak_m = 0;  // model: data grants taken while ifetch waited

    mem_req_arbiter #(
        .AW (AW), .DW (DW), .STARVE_LIMIT (LIMIT), .TIMEOUT_CYC (TMO)
    ) dut (
        .cpu_clk_gated (cpu_clk_gated), .i_rstn    (i_rstn),
        .if_req    (if_req),    .if_addr   (if_addr),   .if_gnt   (if_gnt),
        .if_rvalid (if_rvalid), .if_rdata  (if_rdata),
        .d_req     (d_req),     .d_we      (d_we),      .d_func3  (d_func3),
        .d_addr    (d_addr),    .d_wdata   (d_wdata),   .d_gnt    (d_gnt),
        .d_done    (d_done),    .d_rdata   (d_rdata),
        .m_req     (m_req),     .m_we      (m_we),      .m_func3  (m_func3),
        .m_addr    (m_addr),    .m_wdata   (m_wdata),
        .m_done    (m_done),    .m_rvalid  (m_rvalid),  .m_rdata  (m_rdata),
        .arb_busy  (arb_busy),  .arb_timeout (arb_timeout)
    );

    always #5 cpu_clk_gated = ~cpu_clk_gated;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge cpu_clk_gated);
        #1;
    endtask

    task automatic new_d();
        d_req   = 1'b1;
        d_we    = 1'($urandom_range(0, 1));
        d_func3 = 3'($urandom_range(0, 7));
        d_addr  = $urandom;
        d_wdata = $urandom;
    endtask

    task automatic new_if();
        if_req  = 1'b1;
        if_addr = $urandom;
    endtask

    // One transaction with the requests currently held: wait for ISSUE, check the
    // grant and memory fields, answer after 'lat' cycles (optionally with
    // wrong-type pulses before), then check the routed completion.
    task automatic do_txn(input int lat, input logic [DW-1:0] rd, input logic noise,
                          output logic got_d, output int waits);
        logic          exp_d, exp_rd_op, seen;
        logic [AW-1:0] exp_addr;
        exp_d     = d_req && !(if_req && streak_m == LIMIT);
        exp_rd_op = !exp_d || !d_we;
        exp_addr  = exp_d ? d_addr : if_addr;
        got_d     = exp_d;
        seen      = 1'b0;
        waits     = 0;
        while (!seen && waits < 8) begin
            step();
            waits++;
            seen = m_req;
        end
        check("issue_reached", seen, 1'b1);
        if (!seen) return;
        got_d = d_gnt;
        check("d_gnt", d_gnt, exp_d);
        check("if_gnt", if_gnt, !exp_d);
        check("m_addr", m_addr, exp_addr);
        check("m_we", m_we, exp_d && d_we);
        check("m_func3", m_func3, exp_d ? d_func3 : 3'b010);
        if (exp_d && d_we) check("m_wdata", m_wdata, d_wdata);
        if (exp_d) streak_m = if_req ? ((streak_m < LIMIT) ? streak_m + 1 : LIMIT) : 0;
        else       streak_m = 0;
        for (int k = 0; k <= lat; k++) begin
            if (k > 0) begin
                step();
                check("wait_flags", {m_req, d_done, if_rvalid, arb_busy}, 4'b0001);
            end
            m_rdata  = $urandom;
            m_rvalid = 1'b0;
            m_done   = 1'b0;
            if (k == lat) begin
                check("m_addr_hold", m_addr, exp_addr);
                if (exp_rd_op) begin
                    m_rvalid = 1'b1;
                    m_rdata  = rd;
                end else begin
                    m_done = 1'b1;
                end
            end else if (noise) begin
                if (exp_rd_op) m_done = 1'b1;
                else           m_rvalid = 1'b1;
            end
        end
        step();
        m_rvalid = 1'b0;
        m_done   = 1'b0;
        check("d_done", d_done, exp_d);
        check("if_rvalid", if_rvalid, !exp_d);
        check("busy_after", arb_busy, 1'b0);
        if (exp_d && !d_we) check("d_rdata", d_rdata, rd);
        if (!exp_d)         check("if_rdata", if_rdata, rd);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic got_d, seen, fin;
        int   waits, s;
        logic exp_order [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

        i_rstn = 1'b0;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_func3 = '0; d_addr = '0; d_wdata = '0;
        m_done = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
        step();
        step();
        check("reset_outs", |{if_gnt, if_rvalid, if_rdata, d_gnt, d_done, d_rdata, m_req, m_we,
                              m_func3, m_addr, m_wdata, arb_busy, arb_timeout}, 1'b0);
        i_rstn = 1'b1;

        // Reset while a load is waiting for memory
        d_req = 1'b1; d_addr = 32'h40; d_func3 = 3'b010;
        step();
        check("rstwait_issue", d_gnt, 1'b1);
        step();
        step();
        i_rstn = 1'b0;
        #1;
        check("rstwait_busy", arb_busy, 1'b0);
        check("rstwait_outs", |{if_gnt, if_rvalid, d_gnt, d_done, d_rdata, m_req, m_addr,
                                m_func3, arb_timeout}, 1'b0);
        d_req = 1'b0;
        step();
        i_rstn = 1'b1;
        step();
        m_rvalid = 1'b1; m_rdata = 32'h1111_2222;
        step();
        m_rvalid = 1'b0;
        check("rstwait_late_done", d_done, 1'b0);
        step();
        check("rstwait_idle", {d_done, arb_busy}, 2'b00);

        // Single load, memory answers 3 cycles after m_req
        d_req = 1'b1; d_we = 1'b0; d_func3 = 3'b010; d_addr = 32'h100;
        do_txn(3, 32'hCAFE0001, 1'b0, got_d, waits);
        check("load_grant_latency", waits, 1);

        // Store with a stray m_rvalid before m_done
        d_we = 1'b1; d_func3 = 3'b000; d_addr = 32'h204; d_wdata = 32'h55;
        do_txn(2, '0, 1'b1, got_d, waits);
        d_req = 1'b0;

        // Contention: both held for six transactions
        d_req = 1'b1; d_we = 1'b0; d_func3 = 3'b010; d_addr = 32'h300;
        if_req = 1'b1; if_addr = 32'h8000;
        for (int i = 0; i < 6; i++) begin
            do_txn(1, 32'hA000_0000 + i, 1'b0, got_d, waits);
            check("contention_order", got_d, exp_order[i]);
            if (got_d) d_addr = d_addr + 4;
            else       if_addr = if_addr + 4;
        end
        d_req = 1'b0; if_req = 1'b0; streak_m = 0;

        // Early response in the ISSUE cycle
        if_req = 1'b1; if_addr = 32'h8100;
        do_txn(0, 32'h1234_5678, 1'b0, got_d, waits);
        if_req = 1'b0;

        // Lost response on an ifetch
        if_req = 1'b1; if_addr = 32'h2000;
        seen = 1'b0; waits = 0;
        while (!seen && waits < 8) begin
            step();
            waits++;
            seen = m_req;
        end
        check("tmo_if_gnt", if_gnt, 1'b1);
        check("tmo_flag_pre", arb_timeout, 1'b0);
        fin = 1'b0; s = 0;
        while (!fin && s < 40) begin
            step();
            s++;
            fin = if_rvalid;
        end
        check("tmo_cycles", s, TMO + 1);
        check("tmo_rdata", if_rdata, '0);
        check("tmo_flag", arb_timeout, 1'b1);
        if_req = 1'b0; streak_m = 0;
        m_rvalid = 1'b1; m_rdata = 32'hDEAD_BEEF;
        step();
        m_rvalid = 1'b0;
        check("tmo_late_ignored", {if_rvalid, arb_busy}, 2'b00);
        d_req = 1'b1; d_we = 1'b0; d_func3 = 3'b100; d_addr = 32'h500;
        do_txn(2, 32'h0BAD_F00D, 1'b0, got_d, waits);
        check("tmo_sticky", arb_timeout, 1'b1);

        // Randomized traffic
        new_d();
        for (int i = 0; i < 40; i++) begin
            do_txn($urandom_range(0, 6), $urandom, 1'($urandom_range(0, 1)), got_d, waits);
            if (got_d) begin
                if ($urandom_range(0, 3) != 0) new_d();
                else d_req = 1'b0;
            end else begin
                if ($urandom_range(0, 3) != 0) new_if();
                else begin
                    if_req   = 1'b0;
                    streak_m = 0;
                end
            end
            if (!d_req && !if_req) begin
                if ($urandom_range(0, 1) == 1) new_d();
                else new_if();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
